// File: rtl/pipo_load_arbiter.sv
// Round-robin load arbiter sharing one WIDTH-bit PIPO register among N requesters.
// Define PIPO_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module pipo_load_arbiter #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int CNT_W = 8,
    localparam int OW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    input  logic                 hold,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [OW-1:0]        owner,
    output logic                 busy,
    output logic [CNT_W-1:0]     load_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q_valid_q;
    logic [OW-1:0]      owner_q;
    logic               busy_q;
    logic [CNT_W-1:0]   load_cnt_q;
    logic               win_valid;
    logic [OW-1:0]      win_idx;
`ifndef PIPO_ARB_FIXED_PRIO_EN
    logic [OW-1:0]      ptr_q;
    int                 cand;
`endif

    // Winner search; only consulted when IDLE and not held.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
`ifdef PIPO_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_idx   = OW'(i);
            end
        end
`else
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = OW'(cand);
            end
        end
`endif
        gnt_d = N'(1) << win_idx;
        q_d   = data[int'(win_idx)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            load_cnt_q <= '0;
`ifndef PIPO_ARB_FIXED_PRIO_EN
            ptr_q      <= OW'(N - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hold && win_valid) begin
                        state_q    <= GRANT;
                        gnt_q      <= gnt_d;
                        q_q        <= q_d;
                        q_valid_q  <= 1'b1;
                        owner_q    <= win_idx;
                        busy_q     <= 1'b1;
                        load_cnt_q <= load_cnt_q + CNT_W'(1);
`ifndef PIPO_ARB_FIXED_PRIO_EN
                        ptr_q      <= win_idx;
`endif
                    end
                end
                GRANT: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign q        = q_q;
    assign q_valid  = q_valid_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign load_cnt = load_cnt_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Self-checking bench for pipo_load_arbiter: directed vector table, async reset and
// counter-wrap sequences, then random traffic against a behavioural model.
module tb_pipo_load_arbiter;

    localparam int WIDTH = 4;
    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int OW    = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req;
    logic [N*WIDTH-1:0]  data;
    logic                hold;
    logic [N-1:0]        gnt;
    logic [WIDTH-1:0]    q;
    logic                q_valid;
    logic [OW-1:0]       owner;
    logic                busy;
    logic [CNT_W-1:0]    load_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]       req;
        logic [N*WIDTH-1:0] data;
        logic               hold;
        logic [N-1:0]       gnt;
        logic [WIDTH-1:0]   q;
        logic [OW-1:0]      owner;
        logic               busy;
        logic [CNT_W-1:0]   cnt;
    } vec_t;

    vec_t vecs[$];
    int   tableCnt;

    int               mLast;
    bit               mGrant;
    logic [N-1:0]     mGnt;
    logic [WIDTH-1:0] mQ;
    int               mOwner;
    bit               mValid;
    int               mCnt;

    pipo_load_arbiter #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .hold     (hold),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .owner    (owner),
        .busy     (busy),
        .load_cnt (load_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int pickWinner(input logic [N-1:0] r, input int last);
`ifdef PIPO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic modelReset();
        mLast  = N - 1;
        mGrant = 0;
        mGnt   = '0;
        mQ     = '0;
        mOwner = 0;
        mValid = 0;
        mCnt   = 0;
    endtask

    task automatic modelStep();
        int w;
        if (mGrant) begin
            mGrant = 0;
            mGnt   = '0;
        end else if (!hold) begin
            w = pickWinner(req, mLast);
            if (w >= 0) begin
                mGnt   = N'(1) << w;
                mQ     = data[w*WIDTH +: WIDTH];
                mOwner = w;
                mLast  = w;
                mValid = 1;
                mCnt   = (mCnt + 1) % 256;
                mGrant = 1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eGnt,
                               input logic [WIDTH-1:0] eQ, input logic [OW-1:0] eOwner,
                               input logic eValid, input logic eBusy, input logic [CNT_W-1:0] eCnt);
        checks++;
        if ({gnt, q, owner, q_valid, busy, load_cnt} !== {eGnt, eQ, eOwner, eValid, eBusy, eCnt}) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b q=%b owner=%0d valid=%b busy=%b cnt=%0d, expected gnt=%b q=%b owner=%0d valid=%b busy=%b cnt=%0d",
                     name, gnt, q, owner, q_valid, busy, load_cnt, eGnt, eQ, eOwner, eValid, eBusy, eCnt);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*WIDTH-1:0] d, input logic h);
        req  = r;
        data = d;
        hold = h;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus('0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        modelReset();
        checkOutput("resetState", '0, '0, '0, 1'b0, 1'b0, '0);
        reset = 1'b1;
    endtask

    task automatic addVec(input logic [N-1:0] r, input logic [N*WIDTH-1:0] d, input logic h,
                          input logic [N-1:0] g, input logic [WIDTH-1:0] eq, input logic [OW-1:0] o,
                          input logic b, input logic [CNT_W-1:0] c);
        vec_t v;
        v.req = r; v.data = d; v.hold = h; v.gnt = g; v.q = eq; v.owner = o; v.busy = b; v.cnt = c;
        vecs.push_back(v);
    endtask

    // A load takes two rows: the grant cycle, then the forced return to IDLE.
    task automatic addLoad(input logic [N-1:0] r, input logic [N*WIDTH-1:0] d,
                           input logic [N-1:0] g, input logic [WIDTH-1:0] eq, input logic [OW-1:0] o);
        tableCnt++;
        addVec(r, d, 1'b0, g, eq, o, 1'b1, CNT_W'(tableCnt));
        addVec(r, d, 1'b0, '0, eq, o, 1'b0, CNT_W'(tableCnt));
    endtask

    task automatic buildVectors();
        tableCnt = 0;
`ifdef PIPO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) addLoad(4'b1111, 16'hC931, 4'b0001, 4'h1, 2'd0);
`else
        addLoad(4'b1111, 16'hC931, 4'b0001, 4'h1, 2'd0);
        addLoad(4'b1111, 16'hC931, 4'b0010, 4'h3, 2'd1);
        addLoad(4'b1111, 16'hC931, 4'b0100, 4'h9, 2'd2);
        addLoad(4'b1111, 16'hC931, 4'b1000, 4'hC, 2'd3);
        addLoad(4'b1111, 16'hC931, 4'b0001, 4'h1, 2'd0);
`endif
        addLoad(4'b0100, 16'hCE31, 4'b0100, 4'hE, 2'd2);
        for (int i = 0; i < 5; i++)
            addVec(4'b0010, 16'hCE31, 1'b1, '0, 4'hE, 2'd2, 1'b0, CNT_W'(tableCnt));
        addLoad(4'b0010, 16'hCE31, 4'b0010, 4'h3, 2'd1);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus('0, '0, 1'b0);
        buildVectors();
        doReset();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].data, vecs[i].hold);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].owner,
                        1'b1, vecs[i].busy, vecs[i].cnt);
        end

        // Reset in the middle of a grant must clear everything without a clock edge.
        applyStimulus(4'b1000, 16'hC931, 1'b0);
        tick();
        checkOutput("preResetGrant", 4'b1000, 4'hC, 2'd3, 1'b1, 1'b1, CNT_W'(tableCnt + 1));
        #2 reset = 1'b0;
        #1 checkOutput("asyncReset", '0, '0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        modelReset();
        reset = 1'b1;
        tick();
        checkOutput("postResetGrant", 4'b1000, 4'hC, 2'd3, 1'b1, 1'b1, 8'd1);

        doReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(4'b0001, 16'h000A, 1'b0);
            tick();
            applyStimulus('0, 16'h000A, 1'b0);
            tick();
            if (i == 254) checkOutput("cnt255", '0, 4'hA, 2'd0, 1'b1, 1'b0, 8'd255);
        end
        checkOutput("cntWrap", '0, 4'hA, 2'd0, 1'b1, 1'b0, 8'd0);

        doReset();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                          16'($urandom), ($urandom_range(0, 3) == 0));
            tick();
            checkOutput($sformatf("rand%0d", i), mGnt, mQ, OW'(mOwner), mValid, mGrant, CNT_W'(mCnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin load arbiter that shares one WIDTH-bit parallel-in parallel-out register among N requesters. Each requester presents a data word with a request; the arbiter grants one requester at a time, loads that word into the shared register, and reports ownership and load count. It sits between the requesting blocks and the PIPO storage, and contains that register internally as q.

## Interface
- WIDTH, 4, width of the shared register and of each requester's data word
- N, 4, number of requesters (N >= 2); OW = $clog2(N)
- CNT_W, 8, width of the load counter
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous active-low reset
- req  input  N  request per requester; bit i belongs to requester i
- data  input  N*WIDTH  requester i's word on data[i*WIDTH +: WIDTH]
- hold  input  1  freeze: no new grants while high
- gnt  output  N  registered one-hot grant; all zeros when idle
- q  output  WIDTH  shared register contents
- q_valid  output  1  high once q has been loaded at least once since reset
- owner  output  OW  index of the requester whose word is in q
- busy  output  1  high while in GRANT
- load_cnt  output  CNT_W  number of loads since reset, wrapping

## Operation
- Reset, asynchronous on reset low: gnt=0, q=0, q_valid=0, owner=0, busy=0, load_cnt=0, ptr=N-1, state=IDLE. Outputs change immediately, without waiting for a clock edge.
- FSM has two states, IDLE and GRANT.
- IDLE, with hold=0 and req!=0 at an edge:
  - Choose the winner w as the first set req bit, searching from (ptr+1) mod N upward with wrap.
  - At that edge: gnt<=onehot(w), q<=data[w], owner<=w, ptr<=w, q_valid<=1, load_cnt<=load_cnt+1 (mod 2^CNT_W), state<=GRANT.
- IDLE with hold=1 or req==0: stay in IDLE. No register changes.
- GRANT: at the next edge, unconditionally go to IDLE with gnt<=0. Requests are not sampled in GRANT.
- Requester rule: keep req high until gnt is seen, then drop req at the next edge. A req still high in the following IDLE cycle counts as a new request.
- A req that drops before being granted is simply never considered. No request is latched.
- Data is sampled only at the grant edge. data[w] must be stable in that cycle.
- hold rising while in GRANT does not cancel the grant in progress. It blocks the next IDLE decision.
- Round-robin pointer: after reset, requester 0 has highest priority. A requester that was just served becomes lowest priority.

## Timing
- Request-to-grant latency: req high in IDLE at edge k gives gnt and the new q in cycle k+1, both updated on the same edge.
- Each grant lasts exactly 1 cycle. busy mirrors the GRANT state.
- Maximum throughput is one load every 2 cycles.
- q, owner and q_valid hold their values until the next load or reset.
- Reset asserted during GRANT: gnt drops asynchronously. The load already done at the previous edge is discarded (q=0).
- Reset deasserted: the first decision happens at the first rising edge on which reset is high.

## Configuration
- PIPO_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest set req index always wins. ptr is neither maintained nor used. All other behaviour is unchanged.
- PIPO_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
All scenarios use WIDTH=4, N=4, CNT_W=8.
- Reset low mid-run -> q=0000, gnt=0000, owner=0, q_valid=0, busy=0, load_cnt=0, all immediately.
- req=0100, data[2]=1110 -> next cycle gnt=0100, q=1110, owner=2, busy=1, load_cnt=1. The cycle after that: gnt=0000, q still 1110.
- req=1111 held, data = {1100,1001,0011,0001} for i=3..0 -> grants 0001, 0010, 0100, 1000, 0001 every 2 cycles, with q = 0001, 0011, 1001, 1100, 0001.
- hold=1 with req=0010 for 5 cycles -> gnt stays 0000 and q is unchanged. Drop hold -> next cycle gnt=0010 and q=data[1].
- Reset pulsed low during GRANT (gnt=1000) -> gnt=0000 and q=0000 asynchronously. After release with req=1000, the next grant goes to 1000 with load_cnt=1.
- 256 single-requester loads -> load_cnt wraps to 0. With PIPO_ARB_FIXED_PRIO_EN defined and req=1111 held, every grant is 0001.
